// File: rtl/reset_sequencer_if.sv
// Request/status bundle between reset_sequencer and its environment.
// wdog_kick exists only when WATCHDOG_EN is defined.
interface reset_sequencer_if #(
  parameter int NUM_CH = 4
);
  logic              ext_reset_n;
  logic              soft_req;
`ifdef WATCHDOG_EN
  logic              wdog_kick;
`endif
  logic [NUM_CH-1:0] ch_reset;
  logic              all_released;
  logic              busy;
  logic [1:0]        reset_cause;

  modport master (
`ifdef WATCHDOG_EN
    output wdog_kick,
`endif
    output ext_reset_n, soft_req,
    input  ch_reset, all_released, busy, reset_cause
  );

  modport slave (
`ifdef WATCHDOG_EN
    input  wdog_kick,
`endif
    input  ext_reset_n, soft_req,
    output ch_reset, all_released, busy, reset_cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged board reset generator with button debounce, software request and cause capture.
// Optional watchdog (cause 11) is built in when WATCHDOG_EN is defined.
module reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int MIN_PULSE   = 480,
  parameter int STAGE_DELAY = 48,
  parameter int DEBOUNCE    = 16,
  parameter int CNT_W       = 16
`ifdef WATCHDOG_EN
  , parameter int WDOG_TIMEOUT = 48000
`endif
) (
  input  logic              clk_48mhz,
  input  logic              reset,
  reset_sequencer_if.slave  bus
);
  // state      | meaning
  // ST_ASSERT  | all channels held, hold counter running
  // ST_RELEASE | channels released one per STAGE_DELAY, idx = next channel
  // ST_RUN     | all released, waiting for a request
  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] STAGE_LD = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] DEB_LD   = CNT_W'(DEBOUNCE);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [NUM_CH-1:0] ch_q, ch_nxt;
  logic [1:0]        cause_q, cause_nxt;
  logic              all_rel_q, busy_q;

  logic [1:0]        sync_q;
  logic [CNT_W-1:0]  deb_cnt;
  logic              ext_hit, wdog_hit, req;

  // deb_cnt parks at zero while the button stays low, so a held button fires once
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      sync_q  <= 2'b11;
      deb_cnt <= DEB_LD;
    end else begin
      sync_q <= {sync_q[0], bus.ext_reset_n};
      if (sync_q[1])
        deb_cnt <= DEB_LD;
      else if (deb_cnt != '0)
        deb_cnt <= deb_cnt - CNT_W'(1);
    end
  end

  assign ext_hit = !sync_q[1] && (deb_cnt == CNT_W'(1));

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk_48mhz) begin
    if (reset || (state != ST_RUN) || bus.wdog_kick)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign wdog_hit = (state == ST_RUN) && !bus.wdog_kick &&
                    (wd_cnt == WD_W'(WDOG_TIMEOUT - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  assign req = ext_hit | wdog_hit | bus.soft_req;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state     <= ST_ASSERT;
      cnt       <= HOLD_LD;
      idx       <= IDX_ONE;
      ch_q      <= '1;
      cause_q   <= 2'b00;
      all_rel_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      ch_q      <= ch_nxt;
      cause_q   <= cause_nxt;
      all_rel_q <= (state_nxt == ST_RUN);
      busy_q    <= (state_nxt != ST_RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    if (req) begin
      state_nxt = ST_ASSERT;
    end else begin
      case (state)
        ST_ASSERT:  if (cnt == '0) state_nxt = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
        ST_RELEASE: if (cnt == '0 && idx == IDX_LAST) state_nxt = ST_RUN;
        default:    state_nxt = state;
      endcase
    end
  end

  always_comb begin
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    ch_nxt    = ch_q;
    cause_nxt = cause_q;
    if (req) begin
      cnt_nxt   = HOLD_LD;
      idx_nxt   = IDX_ONE;
      ch_nxt    = '1;
      cause_nxt = ext_hit ? 2'b01 : (wdog_hit ? 2'b11 : 2'b10);
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == '0) begin
            ch_nxt[0] = 1'b0;
            cnt_nxt   = STAGE_LD;
            idx_nxt   = IDX_ONE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == '0) begin
            ch_nxt[idx] = 1'b0;
            idx_nxt     = idx + IDX_W'(1);
            cnt_nxt     = STAGE_LD;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: begin
          cnt_nxt = cnt;
        end
      endcase
    end
  end

  assign bus.ch_reset     = ch_q;
  assign bus.all_released = all_rel_q;
  assign bus.busy         = busy_q;
  assign bus.reset_cause  = cause_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output board reset pulse generator.
- Produces NUM_CH staged, active-high reset outputs that release in order with a fixed spacing, so clocks, the bus fabric and peripherals come out of reset in sequence.
- Accepts a debounced external reset button and a one-cycle software reset request, and records the cause of the most recent reset.
- Sits at the top level directly after the 48 MHz clock source; all downstream blocks take their reset from CH_RESET.

Parameters:
NUM_CH, 4, number of staged reset outputs (1..8)
MIN_PULSE, 480, cycles all channels are held asserted before the first release (10 us at 48 MHz)
STAGE_DELAY, 48, cycles between successive channel releases (1 us)
DEBOUNCE, 16, consecutive synchronized-low cycles on EXT_RESET_N required to register a request
CNT_W, 16, counter width; must hold max(MIN_PULSE, STAGE_DELAY, DEBOUNCE)

Ports:
CLK_48MHZ  in  1  system clock
RESET  in  1  synchronous, active-high reset
EXT_RESET_N  in  1  asynchronous active-low button; synchronized internally by 2 flops
SOFT_REQ  in  1  one-cycle software reset request
CH_RESET  out  NUM_CH  staged active-high resets; bit 0 releases first
ALL_RELEASED  out  1  high while every channel is released
BUSY  out  1  high in ASSERT or RELEASE
RESET_CAUSE  out  2  00 = RESET/power, 01 = external, 10 = software, 11 = watchdog

Behaviour:
- Reset (RESET high at a clock edge): CH_RESET all ones, ALL_RELEASED=0, BUSY=1, RESET_CAUSE=00, state=ASSERT, counters and debounce counter cleared, synchronizer flops set to 1.
- FSM states: ASSERT, RELEASE, RUN.
- ASSERT:
  - All channels held high.
  - Counter runs from 0 to MIN_PULSE-1.
  - At the terminal count, CH_RESET[0] clears and the FSM moves to RELEASE with channel index k=1.
- RELEASE:
  - Every STAGE_DELAY cycles, CH_RESET[k] clears and k increments.
  - When CH_RESET[NUM_CH-1] clears, go to RUN; ALL_RELEASED rises in that same cycle and BUSY falls.
  - NUM_CH=1: move directly from ASSERT to RUN.
- Timing: with cycle 0 being the first edge with RESET low, CH_RESET[k] falls at edge MIN_PULSE + k*STAGE_DELAY.
- External request:
  - After the 2-flop synchronizer, a debounce counter counts consecutive low samples; any high sample clears it.
  - Reaching DEBOUNCE generates one request. No further request until the synchronized input returns high.
- Software request: SOFT_REQ sampled high generates a request.
- Request handling (any state): on the next edge, CH_RESET goes all ones, ALL_RELEASED=0, BUSY=1, state=ASSERT, counter=0, and RESET_CAUSE is updated.
  - A request during ASSERT or RELEASE restarts the hold period from 0.
- Simultaneous requests: cause priority is external > watchdog > software; only one restart occurs.
- A RESET edge overrides all requests; RESET_CAUSE becomes 00.
- RESET_CAUSE holds its value until the next reset event.
- No glitches: every output is registered.

Optional Feature:
- Macro WATCHDOG_EN.
- Defined:
  - Adds input WDOG_KICK (1 bit) and parameter WDOG_TIMEOUT (default 48000, 1 ms).
  - In RUN, a counter increments each cycle and clears on WDOG_KICK.
  - Reaching WDOG_TIMEOUT raises a request with cause 11.
  - The counter is held at 0 outside RUN.
- Undefined: the port, parameter and counter are absent, and cause 11 never occurs.

Test Plan (defaults: NUM_CH=4, MIN_PULSE=480, STAGE_DELAY=48):
- Power-up: RESET high for 10 cycles, then low -> CH_RESET falls at edges 480/528/576/624 (bits 0..3); ALL_RELEASED and BUSY change at edge 624; RESET_CAUSE=00.
- Software reset: in RUN, pulse SOFT_REQ for 1 cycle -> next edge CH_RESET=4'hF, RESET_CAUSE=10; release sequence repeats with identical timing.
- Debounce: EXT_RESET_N low for 15 cycles then high -> no reset. Low for 40 cycles -> reset with cause 01, exactly one restart; re-triggers only after EXT_RESET_N goes high and then low again.
- Mid-release restart: SOFT_REQ at edge 540 (ch0 and ch1 already released) -> all channels reassert on the next edge; ch0 then releases 480 cycles later.
- Simultaneous: SOFT_REQ coincides with the debounce terminal count -> single restart, RESET_CAUSE=01. RESET asserted in RELEASE -> RESET_CAUSE=00, CH_RESET=4'hF.
- WATCHDOG_EN with WDOG_TIMEOUT=100: no kick in RUN -> reset with cause 11 after 100 cycles. Kicks every 50 cycles -> no reset.
